// File: rtl/nvm_seq_pkg.sv
// Shared types and constants for the NVM synapse Wishbone sequencer.
// Optional feature macro used by the design: SEQ_TIMEOUT_EN (read timeout).
package nvm_seq_pkg;

  localparam int NUM_MACRO = 16;
  localparam int WB_DW     = 32;
  localparam int CNT_W     = 8;

  localparam logic [WB_DW-1:0] ADDR_MATCH_DEF = 32'h3000_000C;
  localparam logic [CNT_W-1:0] CNT_MAX        = 8'hFF;
  localparam logic [3:0]       SEL_ALL        = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] res;
    if (v == CNT_MAX) begin
      res = CNT_MAX;
    end else begin
      res = v + 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/nvm_seq_cnt.sv
// Saturating bus-cycle counter shared by the write-hold and read-timeout
// limits. Clear has priority over enable. Build macro SEQ_TIMEOUT_EN does
// not affect this file.
module nvm_seq_cnt
  import nvm_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_eq
);

  logic [CNT_W-1:0] r_count;

  // Count register: clear, saturating increment, or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_en) begin
      r_count <= sat_inc(r_count);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_eq = (r_count == i_limit);

endmodule

// File: rtl/nvm_synapse_sequencer.sv
// Wishbone master sequencer for the NVM synapse matrix: one command in,
// one Wishbone cycle out, one response back. Writes self-complete after
// WR_HOLD_CYCLES bus cycles because the matrix may suppress the write ack.
// Build macro SEQ_TIMEOUT_EN enables the read timeout (rsp_err can be 1);
// without it a read waits for its ack indefinitely and rsp_err stays 0.
module nvm_synapse_sequencer
  import nvm_seq_pkg::*;
#(
  parameter logic [WB_DW-1:0] ADDR_MATCH     = ADDR_MATCH_DEF,
  parameter int unsigned      WR_HOLD_CYCLES = 32'd4,
  parameter int unsigned      TIMEOUT_CYCLES = 32'd255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [NUM_MACRO-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [NUM_MACRO-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic [WB_DW-1:0]     wbm_adr_o,
  output logic [WB_DW-1:0]     wbm_dat_o,
  input  logic [WB_DW-1:0]     wbm_dat_i,
  input  logic                 wbm_ack_i
);

  localparam logic [CNT_W-1:0] L_WR_HOLD = CNT_W'(WR_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  seq_state_e             r_state;
  seq_state_e             w_state_nx;
  logic                   r_write;
  logic                   r_cmd_ready;
  logic                   r_cyc;
  logic                   r_stb;
  logic                   r_we;
  logic [3:0]             r_sel;
  logic [WB_DW-1:0]       r_adr;
  logic [WB_DW-1:0]       r_dat_o;
  logic                   r_rsp_valid;
  logic [NUM_MACRO-1:0]   r_rsp_data;
  logic                   r_rsp_err;

  logic                   w_accept;
  logic                   w_done;
  logic                   w_rsp_pop;
  logic [NUM_MACRO-1:0]   w_rsp_data_nx;
  logic                   w_rsp_err_nx;
  logic                   w_cnt_clr;
  logic                   w_cnt_en;
  logic                   w_cnt_eq;
  logic [CNT_W-1:0]       w_limit;
  logic                   w_unused_dat_hi;

  // Only the low half of the read bus carries synapse data.
  assign w_unused_dat_hi = ^wbm_dat_i[WB_DW-1:NUM_MACRO];

  // The single counter compares against whichever limit fits the command.
  assign w_limit = r_write ? L_WR_HOLD : L_TIMEOUT;

  nvm_seq_cnt u_cnt (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .i_limit (w_limit),
    .o_eq    (w_cnt_eq)
  );

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state, completion decode and counter control.
  always_comb begin
    w_state_nx    = r_state;
    w_accept      = 1'b0;
    w_done        = 1'b0;
    w_rsp_pop     = 1'b0;
    w_rsp_data_nx = {NUM_MACRO{1'b0}};
    w_rsp_err_nx  = 1'b0;
    w_cnt_clr     = 1'b0;
    w_cnt_en      = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          // Accept edge loads the counter to 1 for the first BUS cycle.
          w_accept   = 1'b1;
          w_cnt_en   = 1'b1;
          w_state_nx = BUS;
        end else begin
          w_cnt_clr  = 1'b1;
          w_state_nx = IDLE;
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          // Ack wins over any limit reached in the same cycle.
          w_done        = 1'b1;
          w_rsp_data_nx = r_write ? {NUM_MACRO{1'b0}} : wbm_dat_i[NUM_MACRO-1:0];
          w_state_nx    = RESP;
        end else if (r_write && w_cnt_eq) begin
          w_done     = 1'b1;
          w_state_nx = RESP;
`ifdef SEQ_TIMEOUT_EN
        end else if (!r_write && w_cnt_eq) begin
          w_done       = 1'b1;
          w_rsp_err_nx = 1'b1;
          w_state_nx   = RESP;
`endif
        end else begin
`ifdef SEQ_TIMEOUT_EN
          w_cnt_en = 1'b1;
`else
          w_cnt_en = r_write;
`endif
          w_state_nx = BUS;
        end
      end
      RESP: begin
        w_cnt_clr = 1'b1;
        if (rsp_ready) begin
          w_rsp_pop  = 1'b1;
          w_state_nx = IDLE;
        end else begin
          w_state_nx = RESP;
        end
      end
      default: begin
        w_cnt_clr  = 1'b1;
        w_state_nx = IDLE;
      end
    endcase
  end

  // Latch the command type for the duration of the transaction.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_write <= 1'b0;
    end else if (w_accept) begin
      r_write <= cmd_write;
    end else begin
      r_write <= r_write;
    end
  end

  // Wishbone outputs: set on accept, held through BUS, cleared on completion.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= 4'h0;
      r_adr   <= {WB_DW{1'b0}};
      r_dat_o <= {WB_DW{1'b0}};
    end else if (w_accept) begin
      r_cyc   <= 1'b1;
      r_stb   <= 1'b1;
      r_we    <= cmd_write;
      r_sel   <= SEL_ALL;
      r_adr   <= ADDR_MATCH;
      r_dat_o <= {{(WB_DW-NUM_MACRO){1'b0}}, cmd_data};
    end else if (w_done || (r_state != BUS)) begin
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= 4'h0;
      r_adr   <= {WB_DW{1'b0}};
      r_dat_o <= {WB_DW{1'b0}};
    end else begin
      r_cyc   <= r_cyc;
      r_stb   <= r_stb;
      r_we    <= r_we;
      r_sel   <= r_sel;
      r_adr   <= r_adr;
      r_dat_o <= r_dat_o;
    end
  end

  // Command handshake: ready only while the sequencer will sit in IDLE.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cmd_ready <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_nx == IDLE);
    end
  end

  // Response register: captured at completion, held until consumed.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= {NUM_MACRO{1'b0}};
      r_rsp_err   <= 1'b0;
    end else if (w_done) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_rsp_data_nx;
      r_rsp_err   <= w_rsp_err_nx;
    end else if (w_rsp_pop) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= {NUM_MACRO{1'b0}};
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= r_rsp_valid;
      r_rsp_data  <= r_rsp_data;
      r_rsp_err   <= r_rsp_err;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
`ifdef SEQ_TIMEOUT_EN
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_err   = 1'b0;
`endif
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_stb;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat_o;

`ifndef SEQ_TIMEOUT_EN
  logic w_unused_err;
  assign w_unused_err = r_rsp_err;
`endif

endmodule
